// File: rtl/wash_cycle_sequencer.sv
// rtl/wash_cycle_sequencer.sv - coin-start washer sequencer: fill, N wash/rinse rounds, spin, with pause and abort
// Optional macro WSEQ_PAUSE_ALL_PHASES_EN: timer_pause freezes every phase instead of only SPIN.
module wash_cycle_sequencer #(
    parameter int CLK_HZ     = 1000000,
    parameter int FILL_S     = 120,
    parameter int WASH_S     = 300,
    parameter int RINSE_S    = 120,
    parameter int SPIN_S     = 60,
    parameter int MAX_ROUNDS = 3,
    parameter int RND_W      = 2,
    parameter int SEC_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_in,
    input  logic [RND_W-1:0] wash_rounds,
    input  logic             timer_pause,
    input  logic             abort,
    output logic             wash_done,
    output logic             busy,
    output logic             paused,
    output logic [2:0]       phase,
    output logic [RND_W-1:0] round,
    output logic [SEC_W-1:0] sec_left
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [SEC_W-1:0] FILL_T   = SEC_W'(FILL_S);
    localparam logic [SEC_W-1:0] WASH_T   = SEC_W'(WASH_S);
    localparam logic [SEC_W-1:0] RINSE_T  = SEC_W'(RINSE_S);
    localparam logic [SEC_W-1:0] SPIN_T   = SEC_W'(SPIN_S);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
    localparam logic [RND_W-1:0] MAX_R    = RND_W'(MAX_ROUNDS);
    localparam logic [RND_W-1:0] ONE_R    = RND_W'(1);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4
    } phase_e;

    phase_e           phase_q, phase_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [RND_W-1:0] rounds_q, rounds_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             done_q, done_d;
    logic             paused_q, paused_d;
    logic             aborted_q, aborted_d;
    logic             busy_q, busy_d;
    logic             can_pause;
    logic             tick;

`ifdef WSEQ_PAUSE_ALL_PHASES_EN
    assign can_pause = (phase_q != PH_IDLE);
`else
    assign can_pause = (phase_q == PH_SPIN);
`endif

    assign tick = (presc_q == PRE_LAST);

    always_comb begin
        phase_d   = phase_q;
        round_d   = round_q;
        rounds_d  = rounds_q;
        sec_d     = sec_q;
        presc_d   = presc_q;
        done_d    = done_q;
        paused_d  = 1'b0;
        aborted_d = aborted_q;

        if (phase_q == PH_IDLE) begin
            if (coin_in) begin
                done_d    = 1'b0;
                aborted_d = 1'b0;
                round_d   = ONE_R;
                phase_d   = PH_FILL;
                sec_d     = FILL_T;
                presc_d   = '0;
                if (wash_rounds == '0) begin
                    rounds_d = ONE_R;
                end else if (wash_rounds > MAX_R) begin
                    rounds_d = MAX_R;
                end else begin
                    rounds_d = wash_rounds;
                end
            end
        end else if (abort && (phase_q != PH_SPIN)) begin
            // Drain spin; remembered so its completion does not report a finished wash.
            phase_d   = PH_SPIN;
            sec_d     = SPIN_T;
            presc_d   = '0;
            aborted_d = 1'b1;
        end else if (timer_pause && can_pause) begin
            paused_d = 1'b1;
        end else if (!tick) begin
            presc_d = presc_q + PRE_ONE;
        end else begin
            presc_d = '0;
            if (sec_q > SEC_ONE) begin
                sec_d = sec_q - SEC_ONE;
            end else begin
                case (phase_q)
                    PH_FILL: begin
                        phase_d = PH_WASH;
                        sec_d   = WASH_T;
                    end
                    PH_WASH: begin
                        phase_d = PH_RINSE;
                        sec_d   = RINSE_T;
                    end
                    PH_RINSE: begin
                        if (round_q < rounds_q) begin
                            round_d = round_q + ONE_R;
                            phase_d = PH_WASH;
                            sec_d   = WASH_T;
                        end else begin
                            phase_d = PH_SPIN;
                            sec_d   = SPIN_T;
                        end
                    end
                    default: begin
                        phase_d   = PH_IDLE;
                        sec_d     = '0;
                        round_d   = '0;
                        done_d    = !aborted_q;
                        aborted_d = 1'b0;
                    end
                endcase
            end
        end

        busy_d = (phase_d != PH_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= PH_IDLE;
            round_q   <= '0;
            rounds_q  <= '0;
            sec_q     <= '0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            paused_q  <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            round_q   <= round_d;
            rounds_q  <= rounds_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            paused_q  <= paused_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
        end
    end

    assign wash_done = done_q;
    assign busy      = busy_q;
    assign paused    = paused_q;
    assign phase     = phase_q;
    assign round     = round_q;
    assign sec_left  = sec_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// tb/tb_wash_cycle_sequencer.sv - scoreboard bench for wash_cycle_sequencer against a phase-schedule model
module tb_wash_cycle_sequencer;

    localparam int CLK_HZ     = 4;
    localparam int FILL_S     = 2;
    localparam int WASH_S     = 3;
    localparam int RINSE_S    = 2;
    localparam int SPIN_S     = 1;
    localparam int MAX_ROUNDS = 3;
    localparam int RND_W      = 3;
    localparam int SEC_W      = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             coin_in;
    logic [RND_W-1:0] wash_rounds;
    logic             timer_pause;
    logic             abort;
    logic             wash_done;
    logic             busy;
    logic             paused;
    logic [2:0]       phase;
    logic [RND_W-1:0] round;
    logic [SEC_W-1:0] sec_left;

    wash_cycle_sequencer #(
        .CLK_HZ(CLK_HZ), .FILL_S(FILL_S), .WASH_S(WASH_S), .RINSE_S(RINSE_S),
        .SPIN_S(SPIN_S), .MAX_ROUNDS(MAX_ROUNDS), .RND_W(RND_W), .SEC_W(SEC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coin_in(coin_in), .wash_rounds(wash_rounds),
        .timer_pause(timer_pause), .abort(abort), .wash_done(wash_done), .busy(busy),
        .paused(paused), .phase(phase), .round(round), .sec_left(sec_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int rnd;
        int dur;
    } seg_t;

    typedef struct packed {
        logic             done;
        logic             busy;
        logic             paused;
        logic [2:0]       ph;
        logic [RND_W-1:0] rnd;
        logic [SEC_W-1:0] sec;
    } exp_t;

    seg_t segs[$];
    exp_t sb[$];
    int   m_el = 0;
    bit   m_run = 0, m_done = 0, m_paused = 0, m_aborted = 0;
    int   checks = 0, errors = 0, cyc_no = 0;

    function automatic bit pausable(int ph);
`ifdef WSEQ_PAUSE_ALL_PHASES_EN
        return ph != 0;
`else
        return ph == 4;
`endif
    endfunction

    // Model: a started cycle is a list of (phase, round, seconds) segments consumed by elapsed cycles.
    task automatic model_step(bit r, bit c, int wr, bit p, bit a);
        seg_t s;
        if (!r) begin
            m_run = 0; m_done = 0; m_paused = 0; m_aborted = 0; m_el = 0;
            segs.delete();
        end else if (!m_run) begin
            if (c) begin
                int n;
                n = (wr == 0) ? 1 : ((wr > MAX_ROUNDS) ? MAX_ROUNDS : wr);
                segs.delete();
                segs.push_back('{1, 1, FILL_S});
                for (int i = 1; i <= n; i++) begin
                    segs.push_back('{2, i, WASH_S});
                    segs.push_back('{3, i, RINSE_S});
                end
                segs.push_back('{4, n, SPIN_S});
                m_run = 1; m_el = 0; m_done = 0; m_aborted = 0; m_paused = 0;
            end
        end else if (a && segs[0].ph != 4) begin
            s = '{4, segs[0].rnd, SPIN_S};
            segs.delete();
            segs.push_back(s);
            m_el = 0; m_aborted = 1; m_paused = 0;
        end else if (p && pausable(segs[0].ph)) begin
            m_paused = 1;
        end else begin
            m_paused = 0;
            m_el++;
            if (m_el == segs[0].dur * CLK_HZ) begin
                void'(segs.pop_front());
                m_el = 0;
                if (segs.size() == 0) begin
                    m_run = 0;
                    m_done = !m_aborted;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.done   = m_done;
        e.busy   = m_run;
        e.paused = m_paused;
        if (m_run) begin
            e.ph  = 3'(segs[0].ph);
            e.rnd = RND_W'(segs[0].rnd);
            e.sec = SEC_W'(segs[0].dur - m_el / CLK_HZ);
        end else begin
            e.ph  = '0;
            e.rnd = '0;
            e.sec = '0;
        end
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        cyc_no++;
        model_step(rst_n, coin_in, int'(wash_rounds), timer_pause, abort);
        sb.push_back(model_out());
        #1;
    endtask

    task automatic run(int n);
        repeat (n) cyc();
    endtask

    task automatic start(int wr);
        wash_rounds = RND_W'(wr);
        coin_in = 1'b1;
        cyc();
        coin_in = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                got = '{wash_done, busy, paused, phase, round, sec_left};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got ph=%0d rnd=%0d sec=%0d done=%0b busy=%0b paused=%0b exp ph=%0d rnd=%0d sec=%0d done=%0b busy=%0b paused=%0b",
                             cyc_no, got.ph, got.rnd, got.sec, got.done, got.busy, got.paused,
                             e.ph, e.rnd, e.sec, e.done, e.busy, e.paused);
                end
            end
        end
    end

    initial begin : stimulus
        int pause_cnt;
        rst_n = 1'b0; coin_in = 1'b0; wash_rounds = '0; timer_pause = 1'b0; abort = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(3);

        start(1); run(40);
        start(3); run(85);
        start(0); run(40);
        start(7); run(85);

        // pause mid-SPIN
        start(1); run(29);
        timer_pause = 1'b1; run(10);
        timer_pause = 1'b0; run(10);

        // pause in WASH
        start(1); run(12);
        timer_pause = 1'b1; run(10);
        timer_pause = 1'b0; run(40);

        // abort in WASH, then abort together with pause
        start(1); run(10);
        abort = 1'b1; run(1);
        abort = 1'b0; run(8);
        start(2); run(10);
        abort = 1'b1; timer_pause = 1'b1; run(1);
        abort = 1'b0; run(6);
        timer_pause = 1'b0; run(10);

        // coin held through a cycle and past completion
        wash_rounds = RND_W'(1); coin_in = 1'b1; run(70);
        coin_in = 1'b0; run(40);

        // coin during WASH is ignored
        start(1); run(12);
        coin_in = 1'b1; run(3);
        coin_in = 1'b0; run(30);

        // reset mid-RINSE, then a reset pulse that sees no clock edge
        start(1); run(22);
        rst_n = 1'b0; run(1);
        rst_n = 1'b1; run(3);
        start(1); run(5);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        run(40);

        pause_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            coin_in     = ($urandom % 10) == 0;
            wash_rounds = RND_W'($urandom % 8);
            abort       = ($urandom % 150) == 0;
            rst_n       = ($urandom % 800) != 0;
            if (pause_cnt > 0) begin
                pause_cnt--;
                timer_pause = 1'b1;
            end else if (($urandom % 60) == 0) begin
                pause_cnt = $urandom_range(1, 12);
                timer_pause = 1'b1;
            end else begin
                timer_pause = 1'b0;
            end
            cyc();
        end

        rst_n = 1'b1; coin_in = 1'b0; abort = 1'b0; timer_pause = 1'b0;
        run(2);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
